day012_ram_arbiter: RTL and testbench

//  Shares one single-port RAM (async read, sync write, addr/data/wr_en) between NUM_REQ requesters.

---
 rtl/day012_ram_arb_pkg.sv | 31 +++
 rtl/day012_rr_picker.sv | 38 +++
 rtl/day012_ram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_day012_ram_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/day012_ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : day012_ram_arb_pkg
// Brief  : Shared types, default sizes and width helper for the RAM arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package day012_ram_arb_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_MAX_LOCK   = 4;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Bits needed to index `value` items; never less than 1 so a
  // single-entry space still yields a legal vector width.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << width) < value) width = width + 1;
    end
    return width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/day012_rr_picker.sv
`default_nettype none
// ============================================================================
// Module : day012_rr_picker
// Brief  : Combinational rotating-priority encoder. Starting at index ptr and
//          wrapping mod NUM_REQ, the first asserted req wins (one-hot gnt).
// Rev    : 1.0 - initial release
// ============================================================================
module day012_rr_picker
  import day012_ram_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int PTR_WIDTH = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [PTR_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   gnt
);

  int   w_idx;
  logic w_found;

  // Walk the requesters from ptr upward, wrapping once, and keep the first hit.
  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_idx = int'(ptr) + off;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/day012_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : day012_ram_arbiter
// Brief  : Round-robin arbiter sharing one single-port RAM (async read, sync
//          write) among NUM_REQ valid/ready requesters. Reads return a
//          one-cycle response pulse with registered data.
//          Build option RAM_ARB_LOCK_EN: honour req_lock_i with a bounded
//          (MAX_LOCK) burst lock held by a small ARB/LOCKED FSM.
// Rev    : 1.0 - initial release
// ============================================================================
module day012_ram_arbiter
  import day012_ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = clog2(DEPTH),
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int MAX_LOCK   = DEF_MAX_LOCK
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  input  logic [NUM_REQ-1:0]            req_lock_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
  output logic [ADDR_WIDTH-1:0]         ram_addr_o,
  output logic                          ram_wr_en_o,
  output logic [DATA_WIDTH-1:0]         ram_data_o,
  input  logic [DATA_WIDTH-1:0]         ram_data_i
);

  localparam int                   PTR_WIDTH = clog2(NUM_REQ);
  localparam logic [PTR_WIDTH-1:0] LAST_IDX  = PTR_WIDTH'(NUM_REQ - 1);

  logic [PTR_WIDTH-1:0]  r_rr_ptr;
  logic [NUM_REQ-1:0]    w_pick;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [PTR_WIDTH-1:0]  w_idx;
  logic                  w_accept;
  logic                  w_read;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  day012_rr_picker #(
    .NUM_REQ   (NUM_REQ),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_picker (
    .req (req_valid_i),
    .ptr (r_rr_ptr),
    .gnt (w_pick)
  );

`ifdef RAM_ARB_LOCK_EN
  localparam int                   CNT_WIDTH = clog2(MAX_LOCK + 1);
  localparam logic [CNT_WIDTH-1:0] LOCK_MAX  = CNT_WIDTH'(MAX_LOCK);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  arb_state_t           r_state, w_state_nxt;
  logic [PTR_WIDTH-1:0] r_owner, w_owner_nxt;
  logic [CNT_WIDTH-1:0] r_lock_cnt, w_lock_cnt_nxt;

  // While locked only the owner can be granted; otherwise the rotating pick wins.
  always_comb begin
    w_gnt = '0;
    if (!rst_i) begin
      if (r_state == LOCKED) begin
        if (req_valid_i[r_owner]) w_gnt[r_owner] = 1'b1;
      end else begin
        w_gnt = w_pick;
      end
    end
  end

  // Lock entry, extension, and release (explicit, budget exhausted, or owner idle).
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_state)
      ARB: begin
        if (w_accept && req_lock_i[w_idx] && (MAX_LOCK > 1)) begin
          w_state_nxt    = LOCKED;
          w_owner_nxt    = w_idx;
          w_lock_cnt_nxt = CNT_ONE;
        end
      end
      LOCKED: begin
        if (w_accept && req_lock_i[r_owner] && ((r_lock_cnt + CNT_ONE) < LOCK_MAX)) begin
          w_lock_cnt_nxt = r_lock_cnt + CNT_ONE;
        end else begin
          w_state_nxt    = ARB;
          w_lock_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = ARB;
        w_lock_cnt_nxt = '0;
      end
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ARB;
      r_owner    <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^req_lock_i;

  // Pure round-robin: the rotating pick is the grant, suppressed during reset.
  always_comb begin
    w_gnt = rst_i ? '0 : w_pick;
  end
`endif

  // Binary index of the one-hot grant (0 when nobody is granted).
  always_comb begin
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt[k]) w_idx = PTR_WIDTH'(k);
    end
  end

  assign w_accept    = |w_gnt;
  assign w_sel_addr  = req_addr_i[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_sel_wdata = req_wdata_i[w_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_read      = w_accept & ~req_we_i[w_idx];

  assign req_ready_o = w_gnt;
  assign ram_addr_o  = w_accept ? w_sel_addr : r_addr_hold;
  assign ram_data_o  = w_sel_wdata;
  assign ram_wr_en_o = w_accept & req_we_i[w_idx];
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;

  // Advance the RR pointer past the winner, capture read data, hold the idle address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr    <= '0;
      r_addr_hold <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_read ? w_gnt : '0;
      if (w_accept) begin
        r_rr_ptr    <= (w_idx == LAST_IDX) ? '0 : (w_idx + PTR_WIDTH'(1));
        r_addr_hold <= w_sel_addr;
      end
      if (w_read) r_rsp_rdata <= ram_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_day012_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_day012_ram_arbiter
// Brief  : Directed self-checking bench for day012_ram_arbiter with a small
//          behavioural RAM (async read, sync write) on the RAM pins.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_day012_ram_arbiter;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_we    = '0;
  logic [NR*AW-1:0] req_addr  = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0] req_lock  = '0;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_wr_en;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [0:7];

  int checks = 0;
  int errors = 0;

  day012_ram_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_lock_i  (req_lock),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .ram_addr_o  (ram_addr),
    .ram_wr_en_o (ram_wr_en),
    .ram_data_o  (ram_wdata),
    .ram_data_i  (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: word i resets to 0x10+i, async read, write on posedge.
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'(8'h10 + i);
    end else if (ram_wr_en) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic v, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic lk);
    req_valid[k] = v;
    req_we[k]    = we;
    req_lock[k]  = lk;
    req_addr[k*AW +: AW]  = a;
    req_wdata[k*DW +: DW] = d;
  endtask

  task automatic idle_all();
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    idle_all();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // Reset with traffic pending: grants and write enable are held off.
    next_cycle();
    rst = 1'b1;
    drive(0, 1'b1, 1'b1, 3'd0, 8'h55, 1'b0);
    drive(1, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
    checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", ram_wr_en); end
    next_cycle();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 00", rsp_rdata); end
    // Mid-traffic reset: req0 wins at A, so the pointer moves to 1 before reset.
    next_cycle();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant: got %b expected 01", req_ready); end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL midreset_ready: got %b expected 00", req_ready); end
    next_cycle();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL midreset_rsp_valid: got %b expected 00", rsp_valid); end
    checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL midreset_rsp_rdata: got %h expected 00", rsp_rdata); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midreset_ptr_cleared: got %b expected 01", req_ready); end
    idle_all();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt [0:4];
    logic [7:0] exp_data;
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      if (i < 4) begin
        drive(0, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0);
        drive(1, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0);
      end else begin
        idle_all();
      end
      @(negedge clk);
      checks++; if (req_ready !== exp_gnt[i]) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, req_ready, exp_gnt[i]); end
      if (i > 0) begin
        exp_data = (exp_gnt[i-1] == 2'b01) ? 8'h11 : 8'h12;
        checks++; if (rsp_valid !== exp_gnt[i-1]) begin errors++; $display("FAIL rr_rsp_valid[%0d]: got %b expected %b", i, rsp_valid, exp_gnt[i-1]); end
        checks++; if (rsp_rdata !== exp_data) begin errors++; $display("FAIL rr_rsp_rdata[%0d]: got %h expected %h", i, rsp_rdata, exp_data); end
      end
    end
  endtask

  task automatic test_write_read();
    do_reset();
    next_cycle();
    drive(0, 1'b1, 1'b1, 3'd3, 8'hA5, 1'b0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_grant: got %b expected 01", req_ready); end
    checks++; if (ram_wr_en !== 1'b1) begin errors++; $display("FAIL wr_en: got %b expected 1", ram_wr_en); end
    checks++; if (ram_addr !== 3'd3) begin errors++; $display("FAIL wr_addr: got %0d expected 3", ram_addr); end
    checks++; if (ram_wdata !== 8'hA5) begin errors++; $display("FAIL wr_data: got %h expected a5", ram_wdata); end
    next_cycle();
    drive(0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    drive(1, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rd_grant: got %b expected 10", req_ready); end
    checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL rd_wr_en: got %b expected 0", ram_wr_en); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL wr_no_rsp: got %b expected 00", rsp_valid); end
    next_cycle();
    idle_all();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL rd_rsp_valid: got %b expected 10", rsp_valid); end
    checks++; if (rsp_rdata !== 8'hA5) begin errors++; $display("FAIL rd_rsp_rdata: got %h expected a5", rsp_rdata); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL idle_ready: got %b expected 00", req_ready); end
    checks++; if (ram_addr !== 3'd3) begin errors++; $display("FAIL idle_addr_hold: got %0d expected 3", ram_addr); end
  endtask

  task automatic test_idle_gaps();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive(1, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0);
      @(negedge clk);
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL solo_grant[%0d]: got %b expected 10", i, req_ready); end
    end
    next_cycle();
    idle_all();
    @(negedge clk);
    checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL gap_wr_en: got %b expected 0", ram_wr_en); end
    checks++; if (ram_addr !== 3'd5) begin errors++; $display("FAIL gap_addr_hold: got %0d expected 5", ram_addr); end
    checks++; if (rsp_rdata !== 8'h15) begin errors++; $display("FAIL gap_rsp_rdata: got %h expected 15", rsp_rdata); end
    next_cycle();
    drive(0, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0);
    drive(1, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL gap_next_grant: got %b expected 01", req_ready); end
  endtask

  task automatic test_lock();
    logic [1:0] exp_gnt [0:5];
`ifdef RAM_ARB_LOCK_EN
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
`else
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
    do_reset();
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      drive(0, 1'b1, 1'b0, 3'd1, 8'h00, 1'b1);
      drive(1, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0);
      @(negedge clk);
      checks++; if (req_ready !== exp_gnt[i]) begin errors++; $display("FAIL lock_grant[%0d]: got %b expected %b", i, req_ready, exp_gnt[i]); end
    end
    next_cycle();
    idle_all();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_read();
    test_idle_gaps();
    test_lock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
